// File: rtl/posit_operand_queue.sv
`default_nettype none
// ============================================================================
//  Module      : posit_operand_queue
//  Description : DEPTH-entry operand FIFO in front of the combinational posit
//                multiplier. Each (x, y) pair is classified for zero / NaR at
//                write time so the consumer can bypass the multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_operand_queue #(
  parameter int BITS  = 32,
  parameter int ES    = 3,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BITS-1:0]              in_x,
  input  logic [BITS-1:0]              in_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BITS-1:0]              out_x,
  output logic [BITS-1:0]              out_y,
  output logic                         out_special,
  output logic [BITS-1:0]              out_special_val,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  // NaR encoding: sign bit set, all other bits clear.
  localparam logic [BITS-1:0]  NAR_PAT  = {1'b1, {(BITS-1){1'b0}}};

  // ES only shapes the multiplier itself; the queue stores raw encodings.
  localparam int ES_UNUSED = ES;

  logic [BITS-1:0]  mem_x   [DEPTH];
  logic [BITS-1:0]  mem_y   [DEPTH];
  logic             mem_sp  [DEPTH];
  logic [BITS-1:0]  mem_spv [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic             push;
  logic             pop;
  logic             x_zero;
  logic             y_zero;
  logic             x_nar;
  logic             y_nar;
  logic             in_special;
  logic [BITS-1:0]  in_special_val;

  // Handshake qualifiers depend only on registered occupancy and flush.
  always_comb begin
    in_ready  = (cnt != CNT_FULL) && !flush;
    out_valid = (cnt != '0) && !flush;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Write-time special-case classification; NaR takes precedence over zero.
  always_comb begin
    x_zero         = (in_x == '0);
    y_zero         = (in_y == '0);
    x_nar          = (in_x == NAR_PAT);
    y_nar          = (in_y == NAR_PAT);
    in_special     = x_zero || y_zero || x_nar || y_nar;
    in_special_val = (x_nar || y_nar) ? NAR_PAT : '0;
  end

  // Pointer and occupancy bookkeeping; flush wins over any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; cleared only by reset, flush leaves contents in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_x[i]   <= '0;
        mem_y[i]   <= '0;
        mem_sp[i]  <= 1'b0;
        mem_spv[i] <= '0;
      end
    end else if (push) begin
      mem_x[wr_ptr]   <= in_x;
      mem_y[wr_ptr]   <= in_y;
      mem_sp[wr_ptr]  <= in_special;
      mem_spv[wr_ptr] <= in_special_val;
    end
  end

  // Head entry drives the multiplier operands directly (no fall-through).
  always_comb begin
    out_x           = mem_x[rd_ptr];
    out_y           = mem_y[rd_ptr];
    out_special     = mem_sp[rd_ptr];
    out_special_val = mem_spv[rd_ptr];
    count           = cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_posit_operand_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_posit_operand_queue
//  Description : Scoreboard bench for posit_operand_queue. Expected pairs are
//                queued when the bench predicts a push and compared when the
//                bench predicts a pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_posit_operand_queue;

  localparam int BITS  = 32;
  localparam int ES    = 3;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        sp;
    logic [31:0] spv;
  } pair_t;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_x;
  logic [BITS-1:0] in_y;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_x;
  logic [BITS-1:0] out_y;
  logic            out_special;
  logic [BITS-1:0] out_special_val;
  logic [CW-1:0]   count;

  int    checks;
  int    failures;
  pair_t sb[$];

  posit_operand_queue #(.BITS(BITS), .ES(ES), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_x            (in_x),
    .in_y            (in_y),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_x           (out_x),
    .out_y           (out_y),
    .out_special     (out_special),
    .out_special_val (out_special_val),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic pair_t model(input logic [31:0] x, input logic [31:0] y);
    pair_t p;
    logic  zx, zy, nx, ny;
    zx    = (x == 32'h0000_0000);
    zy    = (y == 32'h0000_0000);
    nx    = (x == 32'h8000_0000);
    ny    = (y == 32'h8000_0000);
    p.x   = x;
    p.y   = y;
    p.sp  = zx | zy | nx | ny;
    p.spv = (nx | ny) ? 32'h8000_0000 : 32'h0;
    return p;
  endfunction

  // One clock: check predicted status at negedge, account the edge in the model.
  task automatic step();
    bit    exp_push, exp_pop;
    pair_t e;
    @(negedge clk);
    exp_push = in_valid && (sb.size() != DEPTH) && !flush;
    exp_pop  = out_ready && (sb.size() != 0) && !flush;
    check("count", 32'(count), 32'(sb.size()));
    check("in_ready", 32'(in_ready), 32'((sb.size() != DEPTH) && !flush));
    check("out_valid", 32'(out_valid), 32'((sb.size() != 0) && !flush));
    if (exp_pop) begin
      e = sb.pop_front();
      check("pop_x", out_x, e.x);
      check("pop_y", out_y, e.y);
      check("pop_special", 32'(out_special), 32'(e.sp));
      check("pop_special_val", out_special_val, e.spv);
    end
    if (exp_push) sb.push_back(model(in_x, in_y));
    if (flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    out_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_out_x"}, out_x, 32'd0);
    check({tag, "_out_y"}, out_y, 32'd0);
    check({tag, "_out_special"}, 32'(out_special), 32'd0);
    check({tag, "_out_special_val"}, out_special_val, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_x      = '0;
    in_y      = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pair: one-cycle latency, then pop.
    in_valid = 1'b1; in_x = 32'h4000_0000; in_y = 32'h4000_0000;
    step();
    in_valid = 1'b0;
    check("first_out_valid", 32'(out_valid), 32'd1);
    check("first_out_x", out_x, 32'h4000_0000);
    check("first_out_y", out_y, 32'h4000_0000);
    check("first_special", 32'(out_special), 32'd0);
    check("first_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("first_drained_count", 32'(count), 32'd0);
    check("first_drained_valid", 32'(out_valid), 32'd0);

    // Fill to full, then offer a 5th pair while one pop happens.
    for (int i = 1; i <= DEPTH; i++) begin
      in_valid = 1'b1; in_x = 32'h1000_0000 + 32'(i); in_y = 32'h2000_0000 + 32'(i);
      step();
    end
    in_x = 32'h1000_0005; in_y = 32'h2000_0005;
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("full_pop_count", 32'(count), 32'(DEPTH - 1));
    step();
    check("fifth_accepted_count", 32'(count), 32'(DEPTH));
    drain();

    // Special-case classification.
    in_valid = 1'b1; in_x = 32'h0000_0000; in_y = 32'h1234_5678; step();
    in_x = 32'h8000_0000; in_y = 32'h0000_0000; step();
    in_x = 32'h8000_0001; in_y = 32'h7FFF_FFFF; step();
    in_x = 32'h5555_5555; in_y = 32'h8000_0000; step();
    drain();

    // Steady push+pop with occupancy held at 2 across several wraps.
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_x = $urandom; in_y = $urandom; step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      in_x = $urandom; in_y = $urandom;
      step();
      check("steady_count", 32'(count), 32'd2);
    end
    drain();

    // Flush with 3 queued entries and a pair offered in the flush cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_x = 32'h3000_0000 + 32'(i); in_y = 32'h3100_0000 + 32'(i); step();
    end
    flush = 1'b1; in_x = 32'h3F00_0000; in_y = 32'h3E00_0000;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("post_flush_count", 32'(count), 32'd0);
    in_valid = 1'b1; in_x = 32'h3A00_0001; in_y = 32'h3B00_0001; step();
    drain();

    // Asynchronous reset in the middle of a cycle with 3 entries queued.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_x = 32'h6000_0000 + 32'(i); in_y = 32'h6100_0000 + 32'(i); step();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    sb.delete();
    rst_n = 1'b1;
    in_valid = 1'b1; in_x = 32'h7000_0001; in_y = 32'h8000_0000; step();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
